// File: rtl/spi_master_multiword.sv
// SPI master that sends a frame of up to MAX_WORDS_PER_CS words of WORD_WIDTH bits under one chip select.
// Define SPI_MASTER_SCLRX_EN to sample MISO on the returned clock i_sclRX instead of the internal SCLK.
module spi_master_multiword #(
  parameter int WORD_WIDTH        = 18,
  parameter int MAX_WORDS_PER_CS  = 2,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int SPI_MODE          = 0
) (
  input  logic                                  i_Clk,
  input  logic                                  i_Rst,
  input  logic [$clog2(MAX_WORDS_PER_CS+1)-1:0] i_TX_Count,
  input  logic [WORD_WIDTH-1:0]                 i_TX_Byte,
  input  logic                                  i_TX_DV,
  output logic                                  o_TX_Ready,
  output logic [$clog2(MAX_WORDS_PER_CS+1)-1:0] o_RX_Count,
  output logic                                  o_RX_DV,
  output logic [WORD_WIDTH-1:0]                 o_RX_Byte,
  output logic                                  o_SPI_Clk,
  input  logic                                  i_SPI_MISO,
  output logic                                  o_SPI_MOSI,
  output logic                                  o_SPI_CS_n,
  input  logic                                  i_sclRX
);

  localparam int CW = $clog2(MAX_WORDS_PER_CS + 1);
  localparam int EW = $clog2(2 * WORD_WIDTH + 1);
  localparam int HW = $clog2(2 * CLKS_PER_HALF_BIT + 1);
  localparam bit CPOL = ((SPI_MODE & 2) != 0);
  localparam bit CPHA = ((SPI_MODE & 1) != 0);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * WORD_WIDTH);
  localparam logic [HW-1:0] HALF_END  = HW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [HW-1:0] GAP_END   = HW'(2 * CLKS_PER_HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, XFER, RX_WAIT, WAIT_NEXT, CS_HOLD, CS_GAP
  } state_t;

  state_t state, state_next, after_word;

  logic [HW-1:0]         half_cnt;
  logic [EW-1:0]         edge_cnt;
  logic                  sclk;
  logic [WORD_WIDTH-1:0] tx_shift;
  logic [WORD_WIDTH-1:0] rx_shift;
  logic [CW-1:0]         tx_count;
  logic [CW-1:0]         word_cnt;

  logic accept, sclk_edge, lead_edge, shift_tx, capture, miso_bit, word_done, more_words;

  always_comb begin
    accept     = o_TX_Ready & i_TX_DV;
    sclk_edge  = (state == XFER) && (edge_cnt != LAST_EDGE) && (half_cnt == HALF_END);
    lead_edge  = ~edge_cnt[0];
    // CPHA=1 presents the MSB before the first leading edge, so that edge must not shift
    shift_tx   = sclk_edge && (CPHA ? (lead_edge && (edge_cnt != '0)) : !lead_edge);
    more_words = ((CW+1)'(word_cnt) + (CW+1)'(1)) < (CW+1)'(tx_count);
  end

`ifdef SPI_MASTER_SCLRX_EN
  localparam int BW = $clog2(WORD_WIDTH + 1);
  localparam bit SAMPLE_LVL = ~(CPOL ^ CPHA);

  logic [1:0]    scl_sync;
  logic          scl_prev;
  logic [1:0]    miso_sync;
  logic [BW-1:0] rx_bits;

  // MISO is delayed through the same two flops so it lines up with the returned clock
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      scl_sync  <= {2{CPOL}};
      scl_prev  <= CPOL;
      miso_sync <= '0;
    end else begin
      scl_sync  <= {scl_sync[0], i_sclRX};
      scl_prev  <= scl_sync[1];
      miso_sync <= {miso_sync[0], i_SPI_MISO};
    end
  end

  always_comb begin
    capture   = (scl_sync[1] != scl_prev) && (scl_sync[1] == SAMPLE_LVL) &&
                (rx_bits != BW'(WORD_WIDTH)) && (state != IDLE);
    miso_bit  = miso_sync[1];
    word_done = (state == RX_WAIT) && (rx_bits == BW'(WORD_WIDTH));
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst)          rx_bits <= '0;
    else if (word_done) rx_bits <= '0;
    else if (capture)   rx_bits <= rx_bits + BW'(1);
  end
`else
  logic unused_sclrx;
  assign unused_sclrx = i_sclRX;

  always_comb begin
    capture   = sclk_edge && (lead_edge ^ CPHA);
    miso_bit  = i_SPI_MISO;
    word_done = (state == XFER) && (edge_cnt == LAST_EDGE);
  end
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    after_word = more_words ? WAIT_NEXT : CS_HOLD;
    state_next = state;
    case (state)
      IDLE:      if (accept) state_next = CS_SETUP;
      CS_SETUP:  if (half_cnt == HALF_END) state_next = XFER;
      XFER: begin
        if (edge_cnt == LAST_EDGE) begin
`ifdef SPI_MASTER_SCLRX_EN
          state_next = RX_WAIT;
`else
          state_next = after_word;
`endif
        end
      end
      RX_WAIT:   if (word_done) state_next = after_word;
      WAIT_NEXT: if (accept) state_next = XFER;
      CS_HOLD:   if (half_cnt == HALF_END) state_next = CS_GAP;
      CS_GAP:    if (half_cnt == GAP_END) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    o_TX_Ready = !i_Rst && ((state == IDLE) || (state == WAIT_NEXT));
    o_SPI_CS_n = (state == IDLE) || (state == CS_GAP);
    o_SPI_Clk  = sclk;
    o_SPI_MOSI = tx_shift[WORD_WIDTH-1];
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      half_cnt   <= '0;
      edge_cnt   <= '0;
      sclk       <= CPOL;
      tx_shift   <= '0;
      rx_shift   <= '0;
      tx_count   <= '0;
      word_cnt   <= '0;
      o_RX_DV    <= 1'b0;
      o_RX_Byte  <= '0;
      o_RX_Count <= '0;
    end else begin
      if (state_next != state || sclk_edge)
        half_cnt <= '0;
      else if (state == CS_SETUP || state == XFER || state == CS_HOLD || state == CS_GAP)
        half_cnt <= half_cnt + HW'(1);

      if (state != XFER)  edge_cnt <= '0;
      else if (sclk_edge) edge_cnt <= edge_cnt + EW'(1);

      if (sclk_edge) sclk <= ~sclk;

      if (accept)        tx_shift <= i_TX_Byte;
      else if (shift_tx) tx_shift <= {tx_shift[WORD_WIDTH-2:0], 1'b0};

      if (capture) rx_shift <= {rx_shift[WORD_WIDTH-2:0], miso_bit};

      if (accept && state == IDLE) begin
        word_cnt <= '0;
        if (i_TX_Count == '0)                        tx_count <= CW'(1);
        else if (i_TX_Count > CW'(MAX_WORDS_PER_CS)) tx_count <= CW'(MAX_WORDS_PER_CS);
        else                                         tx_count <= i_TX_Count;
      end else if (word_done && more_words) begin
        word_cnt <= word_cnt + CW'(1);
      end

      o_RX_DV <= word_done;
      if (word_done) begin
        o_RX_Byte  <= rx_shift;
        o_RX_Count <= word_cnt;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_multiword.sv
// Scoreboard bench for spi_master_multiword: mode-0 loopback instance and a mode-3 instance with MISO tied high.
module tb_spi_master_multiword;
  localparam int W  = 18;
  localparam int CW = 2;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  exp_t exp0[$];
  exp_t exp3[$];
  int unsigned edges0 = 0;
  int unsigned cs_rises0 = 0;
  int unsigned last_edge_cyc0 = 0;

  logic          rst0 = 1'b1, tx_dv0 = 1'b0;
  logic [CW-1:0] tx_count0 = '0;
  logic [W-1:0]  tx_byte0 = '0;
  logic          tx_ready0, rx_dv0, sclk0, mosi0, cs_n0, miso0, sclrx0;
  logic [CW-1:0] rx_count0;
  logic [W-1:0]  rx_byte0;

  logic          rst3 = 1'b1, tx_dv3 = 1'b0;
  logic [CW-1:0] tx_count3 = '0;
  logic [W-1:0]  tx_byte3 = '0;
  logic          tx_ready3, rx_dv3, sclk3, mosi3, cs_n3, sclrx3;
  logic [CW-1:0] rx_count3;
  logic [W-1:0]  rx_byte3;

  // Returned clock (and, with the macro, the loopback data) arrives 3 cycles late
  logic [2:0] sclk0_d = '0;
  logic [2:0] sclk3_d = '1;
  always @(posedge clk) begin
    sclk0_d <= {sclk0_d[1:0], sclk0};
    sclk3_d <= {sclk3_d[1:0], sclk3};
  end
  assign sclrx0 = sclk0_d[2];
  assign sclrx3 = sclk3_d[2];
`ifdef SPI_MASTER_SCLRX_EN
  logic [2:0] mosi0_d = '0;
  always @(posedge clk) mosi0_d <= {mosi0_d[1:0], mosi0};
  assign miso0 = mosi0_d[2];
`else
  assign miso0 = mosi0;
`endif

  spi_master_multiword #(.WORD_WIDTH(W), .MAX_WORDS_PER_CS(2), .CLKS_PER_HALF_BIT(2), .SPI_MODE(0)) dut0 (
    .i_Clk(clk), .i_Rst(rst0), .i_TX_Count(tx_count0), .i_TX_Byte(tx_byte0), .i_TX_DV(tx_dv0),
    .o_TX_Ready(tx_ready0), .o_RX_Count(rx_count0), .o_RX_DV(rx_dv0), .o_RX_Byte(rx_byte0),
    .o_SPI_Clk(sclk0), .i_SPI_MISO(miso0), .o_SPI_MOSI(mosi0), .o_SPI_CS_n(cs_n0), .i_sclRX(sclrx0)
  );

  spi_master_multiword #(.WORD_WIDTH(W), .MAX_WORDS_PER_CS(2), .CLKS_PER_HALF_BIT(2), .SPI_MODE(3)) dut3 (
    .i_Clk(clk), .i_Rst(rst3), .i_TX_Count(tx_count3), .i_TX_Byte(tx_byte3), .i_TX_DV(tx_dv3),
    .o_TX_Ready(tx_ready3), .o_RX_Count(rx_count3), .o_RX_DV(rx_dv3), .o_RX_Byte(rx_byte3),
    .o_SPI_Clk(sclk3), .i_SPI_MISO(1'b1), .o_SPI_MOSI(mosi3), .o_SPI_CS_n(cs_n3), .i_sclRX(sclrx3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic monitor0();
    logic prev_sclk = 1'b0;
    logic prev_cs = 1'b1;
    exp_t e;
    forever begin
      @(negedge clk);
      if (sclk0 !== prev_sclk) begin
        edges0++;
        last_edge_cyc0 = cyc;
      end
      prev_sclk = sclk0;
      if (cs_n0 === 1'b1 && prev_cs === 1'b0) cs_rises0++;
      prev_cs = cs_n0;
      if (rx_dv0 === 1'b1) begin
        if (exp0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx0_unexpected: got RX_DV with data 0x%0h, expected no pulse", rx_byte0);
        end else begin
          e = exp0.pop_front();
          check("rx0_byte", 32'(rx_byte0), 32'(e.data));
          check("rx0_count", 32'(rx_count0), 32'(e.cnt));
          check("rx0_cs_low", 32'(cs_n0), 32'(0));
`ifdef SPI_MASTER_SCLRX_EN
          check("rx0_late", 32'(cyc - last_edge_cyc0 > 1), 32'(1));
`else
          check("rx0_latency", cyc - last_edge_cyc0, 32'(1));
`endif
        end
      end
    end
  endtask

  task automatic monitor3();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rx_dv3 === 1'b1) begin
        if (exp3.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx3_unexpected: got RX_DV with data 0x%0h, expected no pulse", rx_byte3);
        end else begin
          e = exp3.pop_front();
          check("rx3_byte", 32'(rx_byte3), 32'(e.data));
          check("rx3_count", 32'(rx_count3), 32'(e.cnt));
        end
      end
    end
  endtask

  task automatic send0(input logic [CW-1:0] cnt, input logic [W-1:0] data);
    int unsigned n = 0;
    tick();
    while (!tx_ready0 && n < 2000) begin tick(); n++; end
    check("send0_ready", 32'(tx_ready0), 32'(1));
    tx_count0 = cnt;
    tx_byte0  = data;
    tx_dv0    = 1'b1;
    tick();
    tx_dv0    = 1'b0;
  endtask

  task automatic send3(input logic [CW-1:0] cnt, input logic [W-1:0] data);
    int unsigned n = 0;
    tick();
    while (!tx_ready3 && n < 2000) begin tick(); n++; end
    check("send3_ready", 32'(tx_ready3), 32'(1));
    tx_count3 = cnt;
    tx_byte3  = data;
    tx_dv3    = 1'b1;
    tick();
    tx_dv3    = 1'b0;
  endtask

  task automatic wait_idle0(input string name);
    int unsigned n = 0;
    while (!(cs_n0 && tx_ready0) && n < 2000) begin tick(); n++; end
    check(name, 32'(cs_n0 && tx_ready0), 32'(1));
  endtask

  task automatic wait_ready0(input string name);
    int unsigned n = 0;
    while (!tx_ready0 && n < 2000) begin tick(); n++; end
    check(name, 32'(tx_ready0), 32'(1));
  endtask

  initial begin
    int unsigned e0, c0, n;
    fork
      monitor0();
      monitor3();
    join_none

    // Reset values
    repeat (3) tick();
    check("rst_cs_n", 32'(cs_n0), 32'(1));
    check("rst_sclk0", 32'(sclk0), 32'(0));
    check("rst_mosi", 32'(mosi0), 32'(0));
    check("rst_ready", 32'(tx_ready0), 32'(0));
    check("rst_rx_dv", 32'(rx_dv0), 32'(0));
    check("rst_rx_byte", 32'(rx_byte0), 32'(0));
    check("rst_rx_count", 32'(rx_count0), 32'(0));
    check("rst_sclk3", 32'(sclk3), 32'(1));
    rst0 = 1'b0;
    rst3 = 1'b0;
    tick();
    check("ready_after_rst", 32'(tx_ready0), 32'(1));

    // Single word loopback
    e0 = edges0; c0 = cs_rises0;
    exp0.push_back({18'h3AAAA, 2'd0});
    send0(2'd1, 18'h3AAAA);
    wait_idle0("idle_single");
    check("edges_single", edges0 - e0, 32'd36);
    check("cs_rises_single", cs_rises0 - c0, 32'd1);

    // Two-word frame with a 20-cycle gap before the second word
    e0 = edges0; c0 = cs_rises0;
    exp0.push_back({18'h12345, 2'd0});
    exp0.push_back({18'h2ABCD, 2'd1});
    send0(2'd2, 18'h12345);
    wait_ready0("wait_next_ready");
    check("wait_next_sclk", 32'(sclk0), 32'(0));
    check("wait_next_cs", 32'(cs_n0), 32'(0));
    n = edges0;
    repeat (20) tick();
    check("wait_next_no_edges", edges0 - n, 32'd0);
    check("wait_next_cs_held", 32'(cs_n0), 32'(0));
    send0(2'd0, 18'h2ABCD);
    wait_idle0("idle_double");
    check("edges_double", edges0 - e0, 32'd72);
    check("cs_rises_double", cs_rises0 - c0, 32'd1);

    // Count above maximum clamps to two words
    e0 = edges0; c0 = cs_rises0;
    exp0.push_back({18'h00001, 2'd0});
    exp0.push_back({18'h3FFFE, 2'd1});
    send0(2'd3, 18'h00001);
    wait_ready0("clamp_ready");
    send0(2'd3, 18'h3FFFE);
    wait_idle0("idle_clamp");
    check("edges_clamp", edges0 - e0, 32'd72);
    check("cs_rises_clamp", cs_rises0 - c0, 32'd1);

    // Count zero behaves as one
    e0 = edges0;
    exp0.push_back({18'h20001, 2'd0});
    send0(2'd0, 18'h20001);
    wait_idle0("idle_count0");
    check("edges_count0", edges0 - e0, 32'd36);

    // TX_DV during XFER is ignored
    e0 = edges0;
    exp0.push_back({18'h15555, 2'd0});
    send0(2'd1, 18'h15555);
    repeat (10) tick();
    tx_byte0 = 18'h3FFFF;
    tx_dv0   = 1'b1;
    tick();
    tx_dv0   = 1'b0;
    wait_idle0("idle_ignore");
    check("edges_ignore", edges0 - e0, 32'd36);

    // Reset after the 10th SCLK edge aborts the word
    e0 = edges0;
    send0(2'd1, 18'h2AAAA);
    n = 0;
    while (edges0 - e0 < 10 && n < 2000) begin tick(); n++; end
    check("abort_reached_edge10", edges0 - e0, 32'd10);
    rst0 = 1'b1;
    tick();
    check("abort_cs_n", 32'(cs_n0), 32'(1));
    check("abort_sclk", 32'(sclk0), 32'(0));
    check("abort_rx_byte", 32'(rx_byte0), 32'(0));
    n = edges0;
    tick();
    rst0 = 1'b0;
    tick();
    check("abort_ready", 32'(tx_ready0), 32'(1));
    repeat (30) tick();
    check("abort_no_edges", edges0 - n, 32'd0);
    check("abort_cs_stays_high", 32'(cs_n0), 32'(1));

    // Mode 3 with MISO tied high
    exp3.push_back({18'h3FFFF, 2'd0});
    send3(2'd1, 18'h00000);
    n = 0;
    while (!(cs_n3 && tx_ready3) && n < 2000) begin tick(); n++; end
    check("idle3", 32'(cs_n3 && tx_ready3), 32'(1));
    check("sclk3_idle_high", 32'(sclk3), 32'(1));

    repeat (10) tick();
    check("exp0_drained", exp0.size(), 32'd0);
    check("exp3_drained", exp3.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_multiword.md
SPI_MASTER_MULTIWORD -- requirements
Module: spi_master_multiword

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 18: bits per SPI word, range 2..32.
REQ-002 SHALL have parameter MAX_WORDS_PER_CS, default 2: maximum words per chip-select assertion, range 1..15.
REQ-003 SHALL have parameter CLKS_PER_HALF_BIT, default 2: i_Clk cycles per SCLK half period, range 1..255.
REQ-004 SHALL have parameter SPI_MODE, default 0: SPI mode 0..3, with CPOL = bit1 and CPHA = bit0.
REQ-005 SHALL have the following ports; CW denotes $clog2(MAX_WORDS_PER_CS+1):
- i_Clk  in  1  sole clock.
- i_Rst  in  1  synchronous, active-high reset.
- i_TX_Count  in  CW  words in this CS frame; sampled with the first accepted word only.
- i_TX_Byte  in  WORD_WIDTH  word to transmit.
- i_TX_DV  in  1  TX word valid.
- o_TX_Ready  out  1  block can accept a word.
- o_RX_Count  out  CW  0-based index of the received word within the frame.
- o_RX_DV  out  1  one-cycle pulse; received word valid.
- o_RX_Byte  out  WORD_WIDTH  received word.
- o_SPI_Clk  out  1  SCLK.
- i_SPI_MISO  in  1  serial data in.
- o_SPI_MOSI  out  1  serial data out.
- o_SPI_CS_n  out  1  chip select, active low.
- i_sclRX  in  1  returned (delayed) SCLK; used only under SCLRX_EN.

Function
REQ-006 SHALL implement states IDLE, CS_SETUP, XFER, RX_WAIT, WAIT_NEXT, CS_HOLD and CS_GAP.
REQ-007 o_TX_Ready SHALL be 1 only in IDLE and WAIT_NEXT; a word is accepted on a cycle where i_TX_DV=1 and o_TX_Ready=1; i_TX_DV at any other time SHALL be ignored.
REQ-008 On acceptance in IDLE, the block SHALL:
- latch i_TX_Count, treating 0 as 1 and clamping values above MAX_WORDS_PER_CS to MAX_WORDS_PER_CS;
- drive o_SPI_CS_n low on the next cycle;
- enter CS_SETUP.
REQ-009 CS_SETUP SHALL last CLKS_PER_HALF_BIT cycles, after which the block enters XFER.
REQ-010 XFER SHALL generate exactly 2*WORD_WIDTH SCLK edges, each half period CLKS_PER_HALF_BIT cycles; o_SPI_Clk SHALL idle at CPOL.
REQ-011 Data SHALL be transmitted and received MSB first.
REQ-012 CPHA=0: the MOSI MSB SHALL be valid from CS assertion; MISO is sampled on leading edges and MOSI shifts on trailing edges.
REQ-013 CPHA=1: MOSI shifts on leading edges and MISO is sampled on trailing edges.
REQ-014 When WORD_WIDTH bits have been received, o_RX_DV SHALL pulse 1 for exactly one cycle with o_RX_Byte and o_RX_Count valid during that cycle; o_RX_Byte and o_RX_Count SHALL hold their values until the next pulse.
REQ-015 After a word, if words remain, the block SHALL enter WAIT_NEXT:
- o_SPI_CS_n stays low and o_SPI_Clk stays at CPOL;
- the block waits indefinitely for the next i_TX_DV;
- on acceptance it enters XFER directly, with no CS_SETUP.
REQ-016 After the last word, the block SHALL hold CS low in CS_HOLD for CLKS_PER_HALF_BIT cycles, then drive o_SPI_CS_n high and spend 2*CLKS_PER_HALF_BIT cycles in CS_GAP before returning to IDLE.
REQ-017 The word counter SHALL reset to 0 at each new frame; o_RX_Count SHALL never exceed the latched count minus 1.

Reset
REQ-018 While i_Rst=1 at a clock edge, the block SHALL be in IDLE with the following output values:
- o_SPI_CS_n=1, o_SPI_Clk=CPOL, o_SPI_MOSI=0, o_TX_Ready=0;
- o_RX_DV=0, o_RX_Byte=0, o_RX_Count=0;
- all internal counters and shift registers cleared.
REQ-019 o_TX_Ready SHALL be 1 on the first cycle after i_Rst deasserts.
REQ-020 Reset asserted mid-frame SHALL abort the transfer: o_SPI_CS_n goes high at that edge and no o_RX_DV is issued for the partial word.

Configuration
REQ-021 Macro SPI_MASTER_SCLRX_EN SHALL select the MISO sampling source; i_sclRX is unused when the macro is undefined.
REQ-022 With SPI_MASTER_SCLRX_EN defined:
- i_sclRX SHALL pass through a 2-flop synchroniser;
- MISO is sampled on the detected sample-edge polarity of the synchronised i_sclRX, not the internal edge;
- after the last SCLK edge, the block SHALL wait in RX_WAIT until WORD_WIDTH bits have been captured, then pulse o_RX_DV.
REQ-023 With SPI_MASTER_SCLRX_EN undefined:
- MISO SHALL be sampled on the internal sample edge;
- RX_WAIT is bypassed;
- o_RX_DV SHALL pulse one cycle after the last SCLK edge.

Verification
REQ-024 Mode 0, defaults, MISO looped back to MOSI: send 0x3AAAA with count 1 -> 36 SCLK edges, o_RX_DV once with o_RX_Byte=0x3AAAA and o_RX_Count=0, then CS_n high.
REQ-025 Count 2, words 0x12345 then 0x2ABCD with a 20-cycle delay before the second DV -> CS_n low throughout, two RX_DV pulses with counts 0 and 1 and matching data.
REQ-026 SPI_MODE=3, MISO tied to 1 -> SCLK idles high, o_RX_Byte=0x3FFFF.
REQ-027 i_TX_DV pulsed during XFER -> ignored: exactly one word transferred, no extra SCLK edges.
REQ-028 i_Rst asserted after the 10th SCLK edge -> CS_n=1 and o_SPI_Clk=CPOL at that edge, no RX_DV, o_TX_Ready=1 on the cycle after release.
REQ-029 SPI_MASTER_SCLRX_EN defined, i_sclRX = o_SPI_Clk delayed 3 cycles, loopback of 0x3AAAA -> o_RX_Byte=0x3AAAA, RX_DV later than without the macro, CS_n deasserted only after RX_DV.
